// File: rtl/tlight_junction.sv
`default_nettype none
// tlight_junction: demand-driven round-robin UK-sequence traffic-light controller.
// Optional pedestrian walk phase is enabled by defining TLIGHT_PED_EN.
module tlight_junction #(
   parameter int N_WAYS    = 4,
   parameter int RA_CYC    = 2,
   parameter int GREEN_MIN = 8,
   parameter int AMBER_CYC = 3,
   parameter int CLEAR_CYC = 2,
   parameter int WALK_CYC  = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_WAYS-1:0]         req,
   input  logic                      ped_req,
   output logic [N_WAYS-1:0]         r,
   output logic [N_WAYS-1:0]         a,
   output logic [N_WAYS-1:0]         g,
   output logic [$clog2(N_WAYS)-1:0] cur_way,
   output logic                      walk
);

   localparam int CW    = $clog2(N_WAYS);
   localparam int MAX_A = (RA_CYC > GREEN_MIN) ? RA_CYC : GREEN_MIN;
   localparam int MAX_B = (AMBER_CYC > CLEAR_CYC) ? AMBER_CYC : CLEAR_CYC;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAXD  = (MAX_C > WALK_CYC) ? MAX_C : WALK_CYC;
   localparam int TW    = ($clog2(MAXD) < 1) ? 1 : $clog2(MAXD);

`ifdef TLIGHT_PED_EN
   typedef enum logic [2:0] {ALL_RED, RED_AMBER, GREEN, AMBER, WALK} state_t;
`else
   typedef enum logic [2:0] {ALL_RED, RED_AMBER, GREEN, AMBER} state_t;
`endif

   state_t              state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [N_WAYS-1:0]   pend_q, pend_d;
   logic [CW-1:0]       cur_way_q, cur_way_d;
   logic [N_WAYS-1:0]   r_q, r_d, a_q, a_d, g_q, g_d;
   logic [N_WAYS-1:0]   req_m, clr, oh_cur, oh_next;
   logic [CW-1:0]       sel;
   logic                sel_found;
   logic                other_pend;
   logic                yield_demand;
   int                  idx;

   function automatic logic [N_WAYS-1:0] onehot(input logic [CW-1:0] w);
      logic [N_WAYS-1:0] v;
      v    = '0;
      v[w] = 1'b1;
      return v;
   endfunction

`ifdef TLIGHT_PED_EN
   logic ped_pend_q, ped_pend_d, walk_q, walk_d, ped_clr;
   assign yield_demand = other_pend | ped_pend_q;
`else
   logic unused_ped_req;
   assign unused_ped_req = ped_req;
   assign yield_demand   = other_pend;
`endif

   assign oh_cur     = onehot(cur_way_q);
   assign other_pend = |(pend_q & ~oh_cur);

   // Round-robin pick: first pending way after cur_way, cur_way itself last.
   always_comb begin
      sel_found = 1'b0;
      sel       = cur_way_q;
      idx       = 0;
      for (int k = 1; k <= N_WAYS; k++) begin
         idx = (int'(cur_way_q) + k) % N_WAYS;
         if (!sel_found && pend_q[idx]) begin
            sel_found = 1'b1;
            sel       = CW'(idx);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
      cur_way_d = cur_way_q;
      clr       = '0;
`ifdef TLIGHT_PED_EN
      ped_clr   = 1'b0;
`endif
      req_m     = req;
      if (state_q == GREEN) req_m = req & ~oh_cur;

      case (state_q)
         ALL_RED: begin
            if (timer_q == '0) begin
`ifdef TLIGHT_PED_EN
               if (ped_pend_q) begin
                  state_d = WALK;
                  timer_d = TW'(WALK_CYC - 1);
                  ped_clr = 1'b1;
               end else
`endif
               if (sel_found) begin
                  state_d   = RED_AMBER;
                  timer_d   = TW'(RA_CYC - 1);
                  cur_way_d = sel;
                  clr       = onehot(sel);
               end
            end
         end
         RED_AMBER: if (timer_q == '0) begin
            state_d = GREEN;
            timer_d = TW'(GREEN_MIN - 1);
         end
         GREEN: if (timer_q == '0 && yield_demand) begin
            state_d = AMBER;
            timer_d = TW'(AMBER_CYC - 1);
         end
         AMBER: if (timer_q == '0) begin
            state_d = ALL_RED;
            timer_d = TW'(CLEAR_CYC - 1);
         end
`ifdef TLIGHT_PED_EN
         WALK: if (timer_q == '0) begin
            state_d = ALL_RED;
            timer_d = TW'(CLEAR_CYC - 1);
         end
`endif
         default: begin
            state_d = ALL_RED;
            timer_d = TW'(CLEAR_CYC - 1);
         end
      endcase

      // A same-edge request for the newly selected way survives to the next decision.
      pend_d = (pend_q & ~clr) | req_m;
`ifdef TLIGHT_PED_EN
      ped_pend_d = (ped_pend_q & ~ped_clr) | ped_req;
`endif
   end

   assign oh_next = onehot(cur_way_d);

   always_comb begin
      r_d = '1;
      a_d = '0;
      g_d = '0;
`ifdef TLIGHT_PED_EN
      walk_d = (state_d == WALK);
`endif
      case (state_d)
         RED_AMBER: a_d = oh_next;
         GREEN: begin
            r_d = ~oh_next;
            g_d = oh_next;
         end
         AMBER: begin
            r_d = ~oh_next;
            a_d = oh_next;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ALL_RED;
         timer_q   <= TW'(CLEAR_CYC - 1);
         pend_q    <= '0;
         cur_way_q <= CW'(N_WAYS - 1);
         r_q       <= '1;
         a_q       <= '0;
         g_q       <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         pend_q    <= pend_d;
         cur_way_q <= cur_way_d;
         r_q       <= r_d;
         a_q       <= a_d;
         g_q       <= g_d;
      end
   end

`ifdef TLIGHT_PED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ped_pend_q <= 1'b0;
         walk_q     <= 1'b0;
      end else begin
         ped_pend_q <= ped_pend_d;
         walk_q     <= walk_d;
      end
   end
   assign walk = walk_q;
`else
   assign walk = 1'b0;
`endif

   assign r       = r_q;
   assign a       = a_q;
   assign g       = g_q;
   assign cur_way = cur_way_q;

endmodule
`default_nettype wire

// File: tb/tb_tlight_junction.sv
`default_nettype none
// tb_tlight_junction: directed + random stimulus checked cycle-by-cycle against a
// phase/elapsed-time reference model of the junction controller.
module tb_tlight_junction;

   localparam int N    = 4;
   localparam int RA   = 2;
   localparam int GMIN = 8;
   localparam int AMB  = 3;
   localparam int CLR  = 2;
   localparam int WLK  = 6;
`ifdef TLIGHT_PED_EN
   localparam bit PED = 1'b1;
`else
   localparam bit PED = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         ped_req = 1'b0;
   logic [N-1:0] r, a, g;
   logic [1:0]   cur_way;
   logic         walk;

   tlight_junction #(
      .N_WAYS(N), .RA_CYC(RA), .GREEN_MIN(GMIN),
      .AMBER_CYC(AMB), .CLEAR_CYC(CLR), .WALK_CYC(WLK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ped_req(ped_req),
      .r(r), .a(a), .g(g), .cur_way(cur_way), .walk(walk)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: named phase, cycles elapsed in it, pending demand.
   localparam int PH_CLEAR = 0, PH_RA = 1, PH_GREEN = 2, PH_AMBER = 3, PH_WALK = 4;
   int m_ph, m_el, m_cur;
   bit m_pend [N];
   bit m_ped;

   task automatic model_reset();
      m_ph = PH_CLEAR; m_el = 0; m_cur = N - 1; m_ped = 1'b0;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] rq, input logic pr);
      int  old_ph, old_cur, w_new;
      bit  go_walk, other;
      old_ph = m_ph; old_cur = m_cur; w_new = -1; go_walk = 1'b0; other = 1'b0;
      m_el++;
      case (m_ph)
         PH_CLEAR: if (m_el >= CLR) begin
            if (PED && m_ped) begin
               m_ph = PH_WALK; m_el = 0; go_walk = 1'b1;
            end else begin
               for (int k = 1; k <= N; k++)
                  if (w_new < 0 && m_pend[(m_cur + k) % N]) w_new = (m_cur + k) % N;
               if (w_new >= 0) begin
                  m_ph = PH_RA; m_el = 0; m_cur = w_new;
               end
            end
         end
         PH_RA: if (m_el >= RA) begin m_ph = PH_GREEN; m_el = 0; end
         PH_GREEN: begin
            for (int i = 0; i < N; i++) if (i != m_cur && m_pend[i]) other = 1'b1;
            if (m_el >= GMIN && (other || (PED && m_ped))) begin m_ph = PH_AMBER; m_el = 0; end
         end
         PH_AMBER: if (m_el >= AMB) begin m_ph = PH_CLEAR; m_el = 0; end
         default:  if (m_el >= WLK) begin m_ph = PH_CLEAR; m_el = 0; end
      endcase
      for (int i = 0; i < N; i++)
         m_pend[i] = (m_pend[i] && i != w_new) || (rq[i] && !(old_ph == PH_GREEN && i == old_cur));
      if (PED) m_ped = (m_ped && !go_walk) || pr;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [N-1:0] er, ea, eg, oh;
      oh = '0; oh[m_cur] = 1'b1;
      er = '1; ea = '0; eg = '0;
      if (m_ph == PH_RA)    ea = oh;
      if (m_ph == PH_GREEN) begin er = ~oh; eg = oh; end
      if (m_ph == PH_AMBER) begin er = ~oh; ea = oh; end
      chk("red",     32'(r),       32'(er));
      chk("amber",   32'(a),       32'(ea));
      chk("green",   32'(g),       32'(eg));
      chk("cur_way", 32'(cur_way), 32'(m_cur));
      chk("walk",    32'(walk),    32'(m_ph == PH_WALK));
   endtask

   task automatic cycle(input logic [N-1:0] rq, input logic pr);
      req = rq; ped_req = pr;
      @(posedge clk);
      model_step(rq, pr);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int guard;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // Idle junction stays all-red with cur_way at the last way.
      repeat (100) cycle('0, 1'b0);
      chk("idle_cur_way", 32'(cur_way), 32'd3);

      // Single demand on way 2, then two competing demands during its green.
      repeat (10) cycle('0, 1'b0);
      cycle(4'b0100, 1'b0);
      repeat (60) cycle('0, 1'b0);
      chk("held_green", 32'(g), 32'b0100);
      cycle(4'b1001, 1'b0);
      repeat (45) cycle('0, 1'b0);

      // Way 1 green, competing request arriving early in its green.
      cycle(4'b0010, 1'b0);
      repeat (6) cycle('0, 1'b0);
      cycle(4'b1000, 1'b0);
      repeat (40) cycle('0, 1'b0);

      // Pedestrian request together with a way-1 request during way-0 green.
      cycle(4'b0001, 1'b0);
      repeat (14) cycle('0, 1'b0);
      cycle(4'b0010, 1'b1);
      repeat (45) cycle('0, 1'b0);

      // Randomised demand.
      for (int n = 0; n < 500; n++)
         cycle(($urandom_range(0, 4) == 0) ? N'($urandom) : '0, ($urandom_range(0, 30) == 0));

      // Asynchronous reset in the middle of a green with demand pending.
      guard = 0;
      while (m_ph != PH_GREEN && guard < 200) begin
         cycle(N'($urandom), 1'b0);
         guard++;
      end
      chk("reach_green", 32'(m_ph == PH_GREEN), 32'd1);
      cycle(4'b1010, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      repeat (30) cycle('0, 1'b0);
      chk("post_reset_red", 32'(r), 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tlight_junction.md
Name: tlight_junction

Overview:
- Parametrised, demand-driven traffic-light controller for an N_WAYS junction. Successor to the single fixed-cycle light.
- Per-way lamps follow the UK sequence RED -> RED+AMBER -> GREEN -> AMBER -> RED, with a timed all-red clearance between ways.
- Vehicle sensors raise sticky requests. Ways are served round-robin; only one way is ever non-red.
- Sits between the sensor/button synchronisers and the lamp drivers.

Parameters:
- N_WAYS, 4, number of approaches (>=2).
- RA_CYC, 2, cycles in RED+AMBER (>=1).
- GREEN_MIN, 8, minimum green cycles before the light may yield (>=1).
- AMBER_CYC, 3, cycles in AMBER (>=1).
- CLEAR_CYC, 2, all-red clearance cycles (>=1).
- WALK_CYC, 6, pedestrian walk cycles; used only with the optional feature (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_WAYS  vehicle-present pulse/level per way, synchronous to clk.
- ped_req  in  1  pedestrian button, synchronous to clk.
- r  out  N_WAYS  red lamp per way.
- a  out  N_WAYS  amber lamp per way.
- g  out  N_WAYS  green lamp per way.
- cur_way  out  $clog2(N_WAYS)  index of the way last selected.
- walk  out  1  pedestrian walk lamp.

Behaviour:
- States: ALL_RED, RED_AMBER, GREEN, AMBER, WALK (WALK only with the optional feature). Lamp outputs and cur_way are registered; walk is registered.
- Phase timer: down-counter, width $clog2 of the largest duration. On entering a timed state it loads duration-1. The state exits on the edge where timer==0 and the exit condition holds. In GREEN the timer saturates at 0.
- Reset (async assert, sync deassert):
  - state=ALL_RED, timer=CLEAR_CYC-1.
  - r=all 1, a=0, g=0, walk=0.
  - pend=0, ped_pend=0, cur_way=N_WAYS-1.
  - Outputs go all-red immediately on rst_n low, mid-phase included.
- Request latching, every edge:
  - pend[i] <= pend[i] | req[i], except for way cur_way while in GREEN, which is not latched.
  - pend[cur_way] clears on entry to RED_AMBER for that way.
- ALL_RED (r=all 1):
  - At timer==0, if pend!=0: select the first set bit scanning cur_way+1, cur_way+2, ... wrapping, with cur_way itself last. Update cur_way and go to RED_AMBER.
  - If pend==0: stay in ALL_RED indefinitely.
- RED_AMBER: r and a set for cur_way only, for RA_CYC cycles, then GREEN.
- GREEN: g set for cur_way only. Exit to AMBER at the first edge with timer==0 (GREEN_MIN elapsed) and any other pend bit set, or ped_pend with the optional feature. With no competing demand the green holds indefinitely.
- AMBER: a set for cur_way only, for AMBER_CYC cycles, then ALL_RED with timer=CLEAR_CYC-1.
- Invariants:
  - Per way, exactly one of {r}, {r,a}, {g}, {a} is active.
  - At most one way has a or g set.
- Simultaneous requests are resolved only by the round-robin order. A request arriving on the same edge as the ALL_RED decision is seen only at the next decision.

Optional Feature:
- Macro TLIGHT_PED_EN.
- With TLIGHT_PED_EN:
  - ped_pend <= ped_pend | ped_req.
  - ped_pend ends GREEN exactly as a vehicle request does.
  - In ALL_RED at timer==0, ped_pend has priority over pend: enter WALK (all r=1, walk=1) for WALK_CYC cycles and clear ped_pend on entry.
  - After WALK, return to ALL_RED with timer=CLEAR_CYC-1. cur_way is unchanged.
- Without TLIGHT_PED_EN: ped_req is ignored, walk is tied 0, no WALK state exists, and ped_pend is absent.

Test Plan:
- Reset, no req for 100 cycles -> r=4'b1111, a=0, g=0, walk=0 throughout; cur_way=3.
- req[2] pulsed 1 cycle at 10 cycles after reset release ->
  - next edge: pend[2]=1;
  - following edge: r=4'b1111, a=4'b0100 for 2 cycles;
  - then g=4'b0100, r=4'b1011, holding for 50+ cycles; cur_way=2.
- During way-2 green (>=8 cycles elapsed), req[0] and req[3] asserted together ->
  - a=4'b0100 for 3 cycles, then all-red for 2 cycles;
  - then way 3 RED_AMBER 2 cycles, green 8 cycles;
  - then amber/clear, and way 0 is served next.
- Way 1 green, req[3] at green cycle 2 -> g[1] held exactly 8 cycles total, then a[1] for 3 cycles.
- rst_n low for 1 cycle mid-GREEN with pend=4'b1010 -> same cycle: r=4'b1111, a=g=0. After release, pend=0 and the controller stays all-red.
- TLIGHT_PED_EN: ped_req and req[1] during way-0 green ->
  - after 8 green + 3 amber + 2 clear cycles: walk=1, r=4'b1111 for 6 cycles;
  - then 2 all-red cycles, then way 1 RED_AMBER.
  - Without the macro, the same stimulus serves way 1 directly and walk stays 0.
